// File: rtl/piso_frame_tx_if.sv
// Handshake and serial-line bundle for piso_frame_tx.
// The producer uses the master side and the transmitter uses the slave side.
interface piso_frame_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             serial_out;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] shift_reg;

  modport master (
    output data_in, load_valid,
    input  load_ready, serial_out, busy, done, shift_reg
  );

  modport slave (
    input  data_in, load_valid,
    output load_ready, serial_out, busy, done, shift_reg
  );
endinterface

// File: rtl/piso_frame_tx.sv
// Parallel-in, serial-out framed transmitter.
// Frame format: start bit (0), data bits, optional even parity, stop bit(s) (1).
module piso_frame_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic              clk,
  input  logic              rst,
  piso_frame_tx_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BMAX = (WIDTH > STOP_BITS) ? WIDTH : STOP_BITS;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  state_t           state,    state_n;
  logic [WIDTH-1:0] shift_q,  shift_n;
  logic             parity_q, parity_n;
  logic             serial_q, serial_n;
  logic             busy_q,   busy_n;
  logic             done_q,   done_n;
  logic [CW-1:0]    clk_cnt,  clk_cnt_n;
  logic [BW-1:0]    bit_cnt,  bit_cnt_n;
  logic             bit_end;

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    if (MSB_FIRST != 0) return v[WIDTH-1];
    else                return v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    if (MSB_FIRST != 0) return v << 1;
    else                return v >> 1;
  endfunction

  assign bus.load_ready = (state == S_IDLE) && !rst;
  assign bus.serial_out = serial_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.shift_reg  = shift_q;

  assign bit_end = (clk_cnt == CLK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      shift_q  <= '0;
      parity_q <= 1'b0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
    end else begin
      state    <= state_n;
      shift_q  <= shift_n;
      parity_q <= parity_n;
      serial_q <= serial_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      clk_cnt  <= clk_cnt_n;
      bit_cnt  <= bit_cnt_n;
    end
  end

  // serial_n always carries the level for the cycle after this edge, so the
  // line is registered and each bit appears exactly at its bit boundary.
  always_comb begin
    state_n   = state;
    shift_n   = shift_q;
    parity_n  = parity_q;
    serial_n  = serial_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
    clk_cnt_n = clk_cnt;
    bit_cnt_n = bit_cnt;

    case (state)
      S_IDLE: begin
        serial_n = 1'b1;
        busy_n   = 1'b0;
        if (bus.load_valid && bus.load_ready) begin
          shift_n   = bus.data_in;
          parity_n  = ^bus.data_in;
          busy_n    = 1'b1;
          serial_n  = 1'b0;
          clk_cnt_n = '0;
          bit_cnt_n = '0;
          state_n   = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          bit_cnt_n = '0;
          serial_n  = head_bit(shift_q);
          state_n   = S_DATA;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          shift_n   = advance(shift_q);
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_n = '0;
            if (PARITY_EN != 0) begin
              serial_n = parity_q;
              state_n  = S_PARITY;
            end else begin
              serial_n = 1'b1;
              state_n  = S_STOP;
            end
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
            serial_n  = head_bit(advance(shift_q));
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          bit_cnt_n = '0;
          serial_n  = 1'b1;
          state_n   = S_STOP;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end

      S_STOP: begin
        serial_n = 1'b1;
        if (bit_end) begin
          clk_cnt_n = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_n = '0;
            busy_n    = 1'b0;
            done_n    = 1'b1;
            state_n   = S_IDLE;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end

      default: begin
        serial_n = 1'b1;
        busy_n   = 1'b0;
        state_n  = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_frame_tx.sv
// Scoreboard bench for piso_frame_tx: three parameterisations share clk/rst;
// expected line levels are queued at stimulus time and popped while busy.
module tb_piso_frame_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  piso_frame_tx_if #(.WIDTH(8)) ifa ();
  piso_frame_tx_if #(.WIDTH(8)) ifb ();
  piso_frame_tx_if #(.WIDTH(8)) ifc ();

  piso_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .STOP_BITS(1), .MSB_FIRST(0))
    u_a (.clk(clk), .rst(rst), .bus(ifa));
  piso_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1), .STOP_BITS(2), .MSB_FIRST(0))
    u_b (.clk(clk), .rst(rst), .bus(ifb));
  piso_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1), .MSB_FIRST(1))
    u_c (.clk(clk), .rst(rst), .bus(ifc));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic qa[$];
  logic qb[$];
  logic qc[$];
  int busy_a = 0, busy_b = 0, busy_c = 0;
  int done_a = 0, done_b = 0, done_c = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon_pop(input string name, input logic line, inout logic q[$]);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: line %b while busy but nothing expected (t=%0t)", name, line, $time);
    end else begin
      chk(name, {31'b0, line}, {31'b0, q.pop_front()});
    end
  endtask

  always @(negedge clk) begin
    if (ifa.busy === 1'b1) begin busy_a++; mon_pop("line_a", ifa.serial_out, qa); end
    if (ifb.busy === 1'b1) begin busy_b++; mon_pop("line_b", ifb.serial_out, qb); end
    if (ifc.busy === 1'b1) begin busy_c++; mon_pop("line_c", ifc.serial_out, qc); end
    if (ifa.done === 1'b1) done_a++;
    if (ifb.done === 1'b1) done_b++;
    if (ifc.done === 1'b1) done_c++;
  end

  // bits[n-1] is the first level on the line; each level lasts cpb cycles
  task automatic push_seq(input int id, input logic [63:0] bits, input int n, input int cpb);
    for (int i = n - 1; i >= 0; i--) begin
      for (int k = 0; k < cpb; k++) begin
        case (id)
          0:       qa.push_back(bits[i]);
          1:       qb.push_back(bits[i]);
          default: qc.push_back(bits[i]);
        endcase
      end
    end
  endtask

  function automatic logic rdy(input int id);
    case (id)
      0:       return ifa.load_ready;
      1:       return ifb.load_ready;
      default: return ifc.load_ready;
    endcase
  endfunction

  function automatic logic bsy(input int id);
    case (id)
      0:       return ifa.busy;
      1:       return ifb.busy;
      default: return ifc.busy;
    endcase
  endfunction

  task automatic drive(input int id, input logic [7:0] d, input logic v);
    case (id)
      0:       begin ifa.data_in = d; ifa.load_valid = v; end
      1:       begin ifb.data_in = d; ifb.load_valid = v; end
      default: begin ifc.data_in = d; ifc.load_valid = v; end
    endcase
  endtask

  task automatic send(input int id, input logic [7:0] d, output int stamp);
    int n;
    n = 0;
    drive(id, d, 1'b1);
    while (rdy(id) !== 1'b1 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL send_timeout: load_ready stayed %b, required 1", rdy(id));
    end
    @(posedge clk);
    stamp = cyc;
    #1;
    drive(id, d, 1'b0);
  endtask

  task automatic wait_idle(input int id);
    int n;
    n = 0;
    while (bsy(id) !== 1'b0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy stayed %b, required 0", bsy(id));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int s1, s2, b0, d0;
    drive(0, 8'h00, 1'b0);
    drive(1, 8'h00, 1'b0);
    drive(2, 8'h00, 1'b0);

    // T1 reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_serial",     {31'b0, ifa.serial_out}, 32'd1);
    chk("rst_busy",       {31'b0, ifa.busy},       32'd0);
    chk("rst_done",       {31'b0, ifa.done},       32'd0);
    chk("rst_shift_reg",  {24'b0, ifa.shift_reg},  32'd0);
    chk("rst_load_ready", {31'b0, ifa.load_ready}, 32'd0);
    chk("rst_ready_b",    {31'b0, ifb.load_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst_a", {31'b0, ifa.load_ready}, 32'd1);
    chk("ready_after_rst_c", {31'b0, ifc.load_ready}, 32'd1);

    // T2 defaults, A5
    b0 = busy_a; d0 = done_a;
    push_seq(0, 64'b0101001011, 10, 1);
    send(0, 8'hA5, s1);
    chk("t2_shift_loaded", {24'b0, ifa.shift_reg}, 32'hA5);
    chk("t2_ready_busy",   {31'b0, ifa.load_ready}, 32'd0);
    wait_idle(0);
    chk("t2_done_pulse",   {31'b0, ifa.done},       32'd1);
    chk("t2_idle_line",    {31'b0, ifa.serial_out}, 32'd1);
    chk("t2_busy_cycles",  busy_a - b0, 32'd10);
    @(posedge clk); #1;
    chk("t2_done_low",     {31'b0, ifa.done},       32'd0);
    chk("t2_done_count",   done_a - d0, 32'd1);
    chk("t2_queue_empty",  qa.size(), 32'd0);

    // T3 parity + 2 stop bits, 07
    b0 = busy_b; d0 = done_b;
    push_seq(1, 64'b011100000111, 12, 1);
    send(1, 8'h07, s1);
    wait_idle(1);
    chk("t3_busy_cycles", busy_b - b0, 32'd12);
    @(posedge clk); #1;
    chk("t3_done_count",  done_b - d0, 32'd1);
    chk("t3_queue_empty", qb.size(), 32'd0);

    // T4 MSB first, 4 clocks per bit, 80
    b0 = busy_c; d0 = done_c;
    push_seq(2, 64'b0100000001, 10, 4);
    send(2, 8'h80, s1);
    wait_idle(2);
    chk("t4_busy_cycles", busy_c - b0, 32'd40);
    @(posedge clk); #1;
    chk("t4_done_count",  done_c - d0, 32'd1);
    chk("t4_queue_empty", qc.size(), 32'd0);

    // T5 back-to-back 01 then FE, plus ignored 55 mid-frame
    b0 = busy_a; d0 = done_a;
    push_seq(0, 64'b0100000001, 10, 1);
    send(0, 8'h01, s1);
    push_seq(0, 64'b0011111111, 10, 1);
    send(0, 8'hFE, s2);
    repeat (3) @(posedge clk);
    #1;
    drive(0, 8'h55, 1'b1);
    @(posedge clk); #1;
    drive(0, 8'h55, 1'b0);
    wait_idle(0);
    chk("t5_accept_spacing", s2 - s1, 32'd11);
    chk("t5_busy_cycles",    busy_a - b0, 32'd20);
    @(posedge clk); #1;
    chk("t5_done_count",     done_a - d0, 32'd2);
    chk("t5_queue_empty",    qa.size(), 32'd0);
    chk("t5_still_idle",     {31'b0, ifa.busy}, 32'd0);

    // T6 reset during data bit 3, then a clean 3C frame
    d0 = done_a;
    push_seq(0, 64'b01010, 5, 1);
    send(0, 8'hA5, s1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_abort_serial", {31'b0, ifa.serial_out}, 32'd1);
    chk("t6_abort_busy",   {31'b0, ifa.busy},       32'd0);
    chk("t6_abort_queue",  qa.size(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_done",      done_a - d0, 32'd0);
    push_seq(0, 64'b0001111001, 10, 1);
    send(0, 8'h3C, s1);
    wait_idle(0);
    @(posedge clk); #1;
    chk("t6_done_count",   done_a - d0, 32'd1);
    chk("t6_queue_empty",  qa.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
